// File: rtl/hilo_ctrl.sv
// Divide sequencer and architectural HI/LO register file behind the multicycle divider.
// Launches the divider, times its fixed latency, and latches quotient/remainder into HI/LO.
//
// state  | meaning
// IDLE   | no division in flight; mthi/mtlo and start are honoured
// LAUNCH | div_init is high this cycle; the latency counter is loaded on exit
// WAIT   | counting down the divider latency; abort/divide-by-zero/capture resolved here
module hilo_ctrl #(
  parameter int DIV_LATENCY = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_divzero,
  output logic        div_init,
  output logic        div_stop,
  output logic        busy,
  output logic        done,
  output logic        div0_exc,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  localparam logic [6:0] CNT_LOAD = 7'(DIV_LATENCY - 1);

  state_t     state;
  logic [6:0] cnt;

  // cnt only changes by reload on LAUNCH->WAIT or by decrement, so cnt==CNT_LOAD
  // inside WAIT identifies the first WAIT edge, where the divider reports divide-by-zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_init <= 1'b0;
      div_stop <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div0_exc <= 1'b0;
    end else begin
      div_init <= 1'b0;
      div_stop <= 1'b0;
      done     <= 1'b0;
      div0_exc <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start) begin
            state    <= LAUNCH;
            div_init <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LAUNCH: begin
          if (abort) begin
            state    <= IDLE;
            div_stop <= 1'b1;
            busy     <= 1'b0;
          end else begin
            state <= WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        WAIT: begin
          if (abort) begin
            state    <= IDLE;
            div_stop <= 1'b1;
            busy     <= 1'b0;
          end else if (cnt == CNT_LOAD && div_divzero) begin
            state    <= IDLE;
            div0_exc <= 1'b1;
            busy     <= 1'b0;
          end else if (cnt == 7'd0) begin
            state <= IDLE;
            hi    <= div_hi;
            lo    <= div_lo;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 7'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl: behavioural divider, high-level HI/LO model, and a
// monitor that pops expected results whenever done or div0_exc fires.
module tb_hilo_ctrl;

  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] div_hi = '0;
  logic [31:0] div_lo = '0;
  logic        div_divzero = 1'b0;
  logic        div_init, div_stop, busy, done, div0_exc;
  logic [31:0] hi, lo;

  hilo_ctrl #(.DIV_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mthi(mthi), .mtlo(mtlo),
    .wdata(wdata), .div_hi(div_hi), .div_lo(div_lo), .div_divzero(div_divzero),
    .div_init(div_init), .div_stop(div_stop), .busy(busy), .done(done),
    .div0_exc(div0_exc), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        exc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          exp_stops = 0;
  int          seen_stops = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '1;
  logic [31:0] lat_a = '0;
  logic [31:0] lat_b = '1;
  int          k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Divider: results become valid LAT cycles after the cycle div_init is high.
  always @(negedge clk) begin
    if (div_init) begin
      k = 1;
      lat_a = op_a;
      lat_b = op_b;
      div_divzero = (op_b == 0);
      div_hi = $urandom;
      div_lo = $urandom;
    end else if (k > 0 && k < LAT + 1) begin
      k++;
      if (k == LAT + 1 && lat_b != 0) begin
        div_hi = lat_a % lat_b;
        div_lo = lat_a / lat_b;
      end else begin
        div_hi = $urandom;
        div_lo = $urandom;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("done_exc_excl", 32'(done & div0_exc), 32'd0);
      chk("init_stop_excl", 32'(div_init & div_stop), 32'd0);
      if (div_stop) seen_stops++;
      if (done || div0_exc) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: done=%b div0_exc=%b, expected nothing", done, div0_exc);
        end else begin
          mon_e = q.pop_front();
          chk("result_kind", 32'(div0_exc), 32'(mon_e.exc));
          chk("result_hi", hi, mon_e.hi);
          chk("result_lo", lo, mon_e.lo);
        end
      end
    end
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int abort_n,
                         input bit coincide_hi, input bit busy_writes, input logic [31:0] cw);
    int natural, exp_len, cyc, busy_cnt;
    bit e_done, e_exc, e_stop;
    op_a = a;
    op_b = b;
    start = 1'b1;
    if (coincide_hi) begin
      mthi = 1'b1;
      wdata = cw;
      m_hi = cw;
    end
    natural = (b == 0) ? 2 : LAT + 1;
    if (abort_n > 0 && abort_n <= natural) begin
      exp_len = abort_n;
      e_stop = 1'b1;
      e_done = 1'b0;
      e_exc = 1'b0;
      exp_stops++;
    end else begin
      exp_len = natural;
      e_stop = 1'b0;
      e_done = (b != 0);
      e_exc = (b == 0);
      if (e_done) begin
        m_hi = a % b;
        m_lo = a / b;
      end
      q.push_back('{exc: e_exc, hi: m_hi, lo: m_lo});
    end
    @(negedge clk);
    start = 1'b0;
    mthi = 1'b0;
    chk("div_init_pulse", 32'(div_init), 32'd1);
    cyc = 1;
    busy_cnt = 0;
    while (busy === 1'b1 && cyc < 200) begin
      busy_cnt++;
      abort = (cyc == abort_n);
      if (busy_writes && cyc == 5 && exp_len > 6) begin
        mtlo = 1'b1;
        start = 1'b1;
        wdata = 32'h12345678;
      end else begin
        mtlo = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0;
    mtlo = 1'b0;
    start = 1'b0;
    chk("busy_len", 32'(busy_cnt), 32'(exp_len));
    chk("done_at_end", 32'(done), 32'(e_done));
    chk("div0_exc_at_end", 32'(div0_exc), 32'(e_exc));
    chk("div_stop_at_end", 32'(div_stop), 32'(e_stop));
    chk("hi_after_op", hi, m_hi);
    chk("lo_after_op", lo, m_lo);
  endtask

  task automatic wr(input bit h, input bit l, input logic [31:0] d);
    mthi = h;
    mtlo = l;
    wdata = d;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    if (h) m_hi = d;
    if (l) m_lo = d;
    chk("wr_hi", hi, m_hi);
    chk("wr_lo", lo, m_lo);
  endtask

  task automatic reset_mid_op();
    op_a = 32'd12345;
    op_b = 32'd17;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_div_init", 32'(div_init), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_div_stop", 32'(div_stop), 32'd0);
    chk("rst_div0_exc", 32'(div0_exc), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'({busy, done, div_stop, div0_exc}), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_n, gap;
    logic [31:0] ra, rb;
    rst = 1'b0;
    start = 1'b1;
    mthi = 1'b1;
    mtlo = 1'b1;
    wdata = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_div_init", 32'(div_init), 32'd0);
    start = 1'b0;
    mthi = 1'b0;
    mtlo = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_outputs", 32'({div_init, div_stop, busy, done, div0_exc}), 32'd0);
      chk("idle_hilo", hi | lo, 32'd0);
    end

    run_div(32'd100, 32'd7, 0, 1'b0, 1'b0, '0);
    chk("hi_100_div_7", hi, 32'd2);
    chk("lo_100_div_7", lo, 32'd14);

    wr(1'b1, 1'b0, 32'hAAAA0000);
    run_div(32'd55, 32'd0, 0, 1'b0, 1'b0, '0);
    chk("hi_kept_on_div0", hi, 32'hAAAA0000);

    run_div(32'd1000, 32'd3, 10, 1'b0, 1'b0, '0);
    @(negedge clk);
    run_div(32'd1000, 32'd3, 0, 1'b0, 1'b0, '0);
    run_div(32'd77, 32'd5, 1, 1'b0, 1'b0, '0);
    run_div(32'd77, 32'd5, 35, 1'b0, 1'b0, '0);
    run_div(32'd77, 32'd0, 2, 1'b0, 1'b0, '0);
    run_div(32'd9, 32'd0, 0, 1'b1, 1'b0, 32'h0BADF00D);

    run_div(32'd500, 32'd9, 0, 1'b0, 1'b1, '0);
    chk("lo_ignores_busy_mtlo", lo, 32'd55);
    wr(1'b0, 1'b1, 32'h12345678);
    chk("lo_idle_mtlo", lo, 32'h12345678);

    reset_mid_op();
    run_div(32'd4096, 32'd10, 0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
           (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      a_n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 36) : 0;
      run_div(ra, rb, a_n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 2) == 0)
        wr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    chk("div_stop_count", 32'(seen_stops), 32'(exp_stops));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
